led_mode_scheduler: RTL and testbench

- Sequences the LED effect drivers (breath, blink, and so on). Exactly one driver is enabled at a time and its output is routed to the physical LED.
- The active mode advances on a debounced push-button press, or automatically after a dwell time.
- Every mode change passes through a blanking gap. The outgoing driver is held in reset and the LED is dark, so each effect restarts cleanly from its reset state.

---
 rtl/led_mode_if.sv | 24 ++
 rtl/led_mode_scheduler.sv | 126 ++++++++++++
 tb/tb_led_mode_scheduler.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_mode_if.sv
// Signal bundle between the LED mode scheduler and its surroundings:
// button/auto controls, driver LED returns, and the selected-mode outputs.
interface led_mode_if #(
    parameter int NUM_MODES = 4,
    parameter int MODE_W    = 2
);
    logic                 btn_next;
    logic                 auto_en;
    logic [NUM_MODES-1:0] mode_led_in;
    logic [NUM_MODES-1:0] mode_en;
    logic [MODE_W-1:0]    cur_mode;
    logic                 led_out;
    logic                 switch_pulse;

    modport master (
        output btn_next, auto_en, mode_led_in,
        input  mode_en, cur_mode, led_out, switch_pulse
    );

    modport slave (
        input  btn_next, auto_en, mode_led_in,
        output mode_en, cur_mode, led_out, switch_pulse
    );
endinterface

// File: rtl/led_mode_scheduler.sv
// Selects one LED effect driver at a time, advancing on a debounced button
// press or a dwell timeout, with a dark blanking gap around every change.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_BLANK | all drivers held in reset, LED dark, counting the gap
//   ST_RUN   | driver cur_mode enabled, its LED routed out, dwell running
module led_mode_scheduler #(
    parameter int NUM_MODES       = 4,
    parameter int MODE_W          = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DWELL_CYCLES    = 1200,
    parameter int BLANK_CYCLES    = 8
) (
    input logic     clk,
    input logic     rst,
    led_mode_if.slave bus
);
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DWW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int BW  = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    typedef enum logic {ST_BLANK = 1'b0, ST_RUN = 1'b1} state_t;

    state_t               state, state_nxt;
    logic                 btn_s1, btn_s2, btn_deb;
    logic [DBW-1:0]       deb_cnt;
    logic [BW-1:0]        blank_cnt, blank_nxt;
    logic [DWW-1:0]       dwell_cnt, dwell_nxt;
    logic [MODE_W-1:0]    mode_q, mode_nxt;
    logic [NUM_MODES-1:0] en_q, en_nxt;
    logic                 led_q, led_nxt;
    logic                 pulse_q, pulse_nxt;
    logic                 deb_flip, press, blank_done, auto_done, advance;

    // The strobe fires in the same cycle the debounced level is about to rise,
    // so the scheduler reacts on the edge that commits the new level.
    assign deb_flip   = (btn_s2 != btn_deb) && (deb_cnt == DBW'(DEBOUNCE_CYCLES - 1));
    assign press      = deb_flip && btn_s2;
    assign blank_done = (blank_cnt == BW'(BLANK_CYCLES - 1));
    assign auto_done  = bus.auto_en && (dwell_cnt == DWW'(DWELL_CYCLES - 1));
    assign advance    = (state == ST_RUN) && (press || auto_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1  <= 1'b0;
            btn_s2  <= 1'b0;
            btn_deb <= 1'b0;
            deb_cnt <= '0;
        end else begin
            btn_s1 <= bus.btn_next;
            btn_s2 <= btn_s1;
            if (btn_s2 == btn_deb) begin
                deb_cnt <= '0;
            end else if (deb_flip) begin
                btn_deb <= btn_s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_BLANK;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_BLANK: if (blank_done) state_nxt = ST_RUN;
            ST_RUN:   if (advance)    state_nxt = ST_BLANK;
            default:  state_nxt = ST_BLANK;
        endcase
    end

    always_comb begin
        blank_nxt = '0;
        dwell_nxt = '0;
        mode_nxt  = mode_q;
        en_nxt    = '0;
        led_nxt   = 1'b0;
        pulse_nxt = 1'b0;
        case (state)
            ST_BLANK: begin
                if (blank_done) en_nxt = NUM_MODES'(1) << mode_q;
                else            blank_nxt = blank_cnt + 1'b1;
            end
            ST_RUN: begin
                if (advance) begin
                    mode_nxt  = (mode_q == MODE_W'(NUM_MODES - 1)) ? '0 : mode_q + 1'b1;
                    pulse_nxt = 1'b1;
                end else begin
                    en_nxt    = en_q;
                    led_nxt   = bus.mode_led_in[mode_q];
                    dwell_nxt = bus.auto_en ? dwell_cnt + 1'b1 : '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_cnt <= '0;
            dwell_cnt <= '0;
            mode_q    <= '0;
            en_q      <= '0;
            led_q     <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            blank_cnt <= blank_nxt;
            dwell_cnt <= dwell_nxt;
            mode_q    <= mode_nxt;
            en_q      <= en_nxt;
            led_q     <= led_nxt;
            pulse_q   <= pulse_nxt;
        end
    end

    assign bus.mode_en      = en_q;
    assign bus.cur_mode     = mode_q;
    assign bus.led_out      = led_q;
    assign bus.switch_pulse = pulse_q;
endmodule

// File: tb/tb_led_mode_scheduler.sv
// Bench for led_mode_scheduler: fixed vector table from reset, directed
// multi-cycle sequences, and random stimulus against a cycle-level model.
module tb_led_mode_scheduler;
    localparam int N  = 4;
    localparam int DB = 4;
    localparam int DW = 20;
    localparam int BL = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    led_mode_if #(.NUM_MODES(N), .MODE_W(2)) bus();

    led_mode_scheduler #(
        .NUM_MODES(N), .MODE_W(2), .DEBOUNCE_CYCLES(DB),
        .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       btn;
        logic       auto_en;
        logic [3:0] li;
        logic [1:0] mode;
        logic [3:0] en;
        logic       led;
        logic       pulse;
    } vec_t;

    vec_t tbl[32];

    // Reference model: button seen two edges late, debounced level flips once
    // the last DB synchronized samples all disagree with it.
    bit       m_s1, m_s2, m_deb;
    bit       hist[$];
    bit       m_run;
    int       m_blank_seen, m_streak, m_mode;
    logic [3:0] m_en;
    bit       m_led, m_pulse;

    function automatic vec_t mk(logic b, logic a, logic [3:0] li, logic [1:0] md,
                                logic [3:0] en, logic led, logic p);
        vec_t v;
        v.btn = b; v.auto_en = a; v.li = li; v.mode = md; v.en = en; v.led = led; v.pulse = p;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_s1 = 0; m_s2 = 0; m_deb = 0; hist.delete();
        m_run = 0; m_blank_seen = 0; m_streak = 0; m_mode = 0;
        m_en = 4'b0; m_led = 0; m_pulse = 0;
    endtask

    task automatic m_step(input bit b, input bit a, input logic [3:0] li);
        bit s_seen, press, all_diff;
        s_seen = m_s2; m_s2 = m_s1; m_s1 = b;
        hist.push_back(s_seen);
        if (hist.size() > DB) void'(hist.pop_front());
        press = 0;
        all_diff = (hist.size() == DB);
        foreach (hist[k]) if (hist[k] == m_deb) all_diff = 0;
        if (all_diff) begin
            m_deb = ~m_deb;
            press = m_deb;
        end
        m_pulse = 0;
        if (!m_run) begin
            m_blank_seen++;
            m_led = 0;
            m_en  = 4'b0;
            if (m_blank_seen == BL) begin
                m_run = 1; m_streak = 0; m_en = 4'b1 << m_mode;
            end
        end else begin
            m_streak = a ? m_streak + 1 : 0;
            if (press || m_streak == DW) begin
                m_mode = (m_mode + 1) % N;
                m_run = 0; m_blank_seen = 0; m_streak = 0;
                m_en = 4'b0; m_led = 0; m_pulse = 1;
            end else begin
                m_led = li[m_mode];
            end
        end
    endtask

    task automatic cycle(input logic b, input logic a, input logic [3:0] li);
        bus.btn_next = b; bus.auto_en = a; bus.mode_led_in = li;
        @(posedge clk);
        m_step(b, a, li);
        @(negedge clk);
        chk("mode",  32'(bus.cur_mode),     32'(m_mode));
        chk("en",    32'(bus.mode_en),      32'(m_en));
        chk("led",   32'(bus.led_out),      32'(m_led));
        chk("pulse", 32'(bus.switch_pulse), 32'(m_pulse));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    initial begin
        int pc, n;
        int seq[4];
        int pj[4];
        int guard;
        logic [3:0] rli;
        bit rb, ra;
        int hold;

        bus.btn_next = 0; bus.auto_en = 0; bus.mode_led_in = 4'b0;

        tbl[0]  = mk(0, 0, 4'b0001, 0, 4'b0000, 0, 0);
        tbl[1]  = mk(0, 0, 4'b0000, 0, 4'b0000, 0, 0);
        tbl[2]  = mk(0, 0, 4'b0001, 0, 4'b0001, 0, 0);
        tbl[3]  = mk(0, 0, 4'b0001, 0, 4'b0001, 1, 0);
        tbl[4]  = mk(0, 0, 4'b1110, 0, 4'b0001, 0, 0);
        tbl[5]  = mk(0, 0, 4'b0001, 0, 4'b0001, 1, 0);
        tbl[6]  = mk(0, 0, 4'b0000, 0, 4'b0001, 0, 0);
        tbl[7]  = mk(0, 0, 4'b1111, 0, 4'b0001, 1, 0);
        tbl[8]  = mk(1, 0, 4'b0001, 0, 4'b0001, 1, 0);
        tbl[9]  = mk(1, 0, 4'b0000, 0, 4'b0001, 0, 0);
        tbl[10] = mk(1, 0, 4'b0001, 0, 4'b0001, 1, 0);
        tbl[11] = mk(1, 0, 4'b0001, 0, 4'b0001, 1, 0);
        tbl[12] = mk(1, 0, 4'b1110, 0, 4'b0001, 0, 0);
        tbl[13] = mk(1, 0, 4'b0001, 1, 4'b0000, 0, 1);
        tbl[14] = mk(1, 0, 4'b0010, 1, 4'b0000, 0, 0);
        tbl[15] = mk(1, 0, 4'b0010, 1, 4'b0000, 0, 0);
        tbl[16] = mk(1, 0, 4'b0010, 1, 4'b0010, 0, 0);
        tbl[17] = mk(1, 0, 4'b0010, 1, 4'b0010, 1, 0);
        tbl[18] = mk(0, 0, 4'b1101, 1, 4'b0010, 0, 0);
        tbl[19] = mk(0, 0, 4'b0010, 1, 4'b0010, 1, 0);
        tbl[20] = mk(0, 0, 4'b0000, 1, 4'b0010, 0, 0);
        tbl[21] = mk(0, 0, 4'b0010, 1, 4'b0010, 1, 0);
        tbl[22] = mk(0, 0, 4'b0010, 1, 4'b0010, 1, 0);
        tbl[23] = mk(0, 0, 4'b0010, 1, 4'b0010, 1, 0);
        tbl[24] = mk(1, 0, 4'b0010, 1, 4'b0010, 1, 0);
        tbl[25] = mk(1, 0, 4'b0010, 1, 4'b0010, 1, 0);
        for (int i = 26; i < 32; i++)
            tbl[i] = (i % 2 == 0) ? mk(0, 0, 4'b0010, 1, 4'b0010, 1, 0)
                                  : mk(0, 0, 4'b1101, 1, 4'b0010, 0, 0);

        // reset state while rst is held
        repeat (2) @(negedge clk);
        chk("rst_mode",  32'(bus.cur_mode), 0);
        chk("rst_en",    32'(bus.mode_en), 0);
        chk("rst_led",   32'(bus.led_out), 0);
        chk("rst_pulse", 32'(bus.switch_pulse), 0);
        rst = 1'b0;

        // startup, LED routing, held press, release, glitch
        for (int i = 0; i < 32; i++) begin
            bus.btn_next = tbl[i].btn; bus.auto_en = tbl[i].auto_en; bus.mode_led_in = tbl[i].li;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl%0d_mode", i),  32'(bus.cur_mode),     32'(tbl[i].mode));
            chk($sformatf("tbl%0d_en", i),    32'(bus.mode_en),      32'(tbl[i].en));
            chk($sformatf("tbl%0d_led", i),   32'(bus.led_out),      32'(tbl[i].led));
            chk($sformatf("tbl%0d_pulse", i), 32'(bus.switch_pulse), 32'(tbl[i].pulse));
        end

        // auto advance through all modes with wrap
        do_reset();
        pc = 0;
        for (int i = 0; i < 4; i++) seq[i] = -1;
        for (int i = 0; i < 95; i++) begin
            cycle(0, 1, 4'($urandom));
            if (bus.switch_pulse) begin
                if (pc < 4) seq[pc] = int'(bus.cur_mode);
                pc++;
            end
        end
        chk("auto_pulses", pc, 4);
        chk("auto_seq0", seq[0], 1);
        chk("auto_seq1", seq[1], 2);
        chk("auto_seq2", seq[2], 3);
        chk("auto_seq3", seq[3], 0);
        chk("auto_wrap_en", 32'(bus.mode_en), 32'(4'b0001));

        // auto_en dropped mid-dwell restarts the full dwell
        repeat (15) cycle(0, 1, 4'($urandom));
        repeat (5)  cycle(0, 0, 4'($urandom));
        n = 0;
        do begin
            cycle(0, 1, 4'($urandom));
            n++;
        end while (!bus.switch_pulse && n < 40);
        chk("redwell_latency", n, 20);
        chk("redwell_mode", 32'(bus.cur_mode), 1);

        // press coinciding with timeout, then a press landing in BLANK
        repeat (3) cycle(0, 1, 4'($urandom));
        pc = 0;
        for (int i = 0; i < 4; i++) begin seq[i] = -1; pj[i] = -1; end
        for (int j = 1; j <= 60; j++) begin
            cycle(((j >= 15 && j <= 30) || (j >= 40 && j <= 50)), 1, 4'($urandom));
            if (bus.switch_pulse) begin
                if (pc < 4) begin seq[pc] = int'(bus.cur_mode); pj[pc] = j; end
                pc++;
            end
        end
        chk("coincide_pulses", pc, 2);
        chk("coincide_at", pj[0], 20);
        chk("coincide_mode", seq[0], 2);
        chk("next_auto_at", pj[1], 43);
        chk("next_auto_mode", seq[1], 3);

        // async reset mid-BLANK with cur_mode=2
        guard = 0;
        while (!(m_pulse && m_mode == 2) && guard < 200) begin
            cycle(0, 1, 4'($urandom));
            guard++;
        end
        chk("reach_mode2", 32'(guard < 200), 1);
        cycle(0, 1, 4'($urandom));
        chk("pre_rst_mode", 32'(bus.cur_mode), 2);
        #2 rst = 1'b1;
        #1;
        chk("async_mode",  32'(bus.cur_mode), 0);
        chk("async_en",    32'(bus.mode_en), 0);
        chk("async_led",   32'(bus.led_out), 0);
        chk("async_pulse", 32'(bus.switch_pulse), 0);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        repeat (2) cycle(0, 0, 4'b1111);
        chk("post_rst_dark", 32'(bus.mode_en), 0);
        cycle(0, 0, 4'b1111);
        chk("post_rst_en", 32'(bus.mode_en), 32'(4'b0001));

        // random stimulus against the model
        rb = 0; ra = 0; hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                rb = ~rb;
                hold = int'($urandom_range(1, 12));
            end
            hold--;
            if ($urandom_range(0, 39) == 0) ra = ~ra;
            rli = 4'($urandom);
            cycle(rb, ra, rli);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
